// File: rtl/mcs4_pkg.sv
// rtl/mcs4_pkg.sv - shared MCS-4 bus phase and I/O opcode definitions
package mcs4_pkg;

  // A1..X3 occupy codes 0..7 so the low three bits double as the debug phase
  typedef enum logic [3:0] {
    PH_A1   = 4'd0,
    PH_A2   = 4'd1,
    PH_A3   = 4'd2,
    PH_M1   = 4'd3,
    PH_M2   = 4'd4,
    PH_X1   = 4'd5,
    PH_X2   = 4'd6,
    PH_X3   = 4'd7,
    PH_IDLE = 4'd8
  } mcs4_phase_e;

  localparam mcs4_phase_e SYNC_PHASE = PH_X3;

  localparam logic [3:0] IO_WRR = 4'h2;
  localparam logic [3:0] IO_RDR = 4'hA;

endpackage

// File: rtl/mcs4_phase_tracker.sv
// rtl/mcs4_phase_tracker.sv - two-phase clock edge strobes and instruction-cycle phase FSM
module mcs4_phase_tracker
  import mcs4_pkg::*;
(
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       clk1,
  input  logic       clk2,
  input  logic       sync,
  output logic [3:0] phase,
  output logic [3:0] phase_nxt,
  output logic       p1,
  output logic       p2f
);

  logic        clk1_q;
  logic        clk2_q;
  logic        sync_q;
  mcs4_phase_e state;
  mcs4_phase_e state_nxt;

  // Registered one-sysclk strobes for clk1 rising and clk2 falling
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      clk1_q <= 1'b0;
      clk2_q <= 1'b0;
      p1     <= 1'b0;
      p2f    <= 1'b0;
    end else begin
      clk1_q <= clk1;
      clk2_q <= clk2;
      p1     <= clk1 & ~clk1_q;
      p2f    <= ~clk2 & clk2_q;
    end
  end

  // sync is judged once per phase, at the clk2 fall preceding the next p1
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 1'b0;
    end else if (p2f) begin
      sync_q <= sync;
    end
  end

  // A captured sync forces A1 from any phase; X3 without sync drops to IDLE
  always_comb begin
    state_nxt = state;
    if (sync_q) begin
      state_nxt = PH_A1;
    end else if (state == SYNC_PHASE || state == PH_IDLE) begin
      state_nxt = PH_IDLE;
    end else begin
      state_nxt = mcs4_phase_e'(state + 4'd1);
    end
  end

  // Phase register advances only on p1
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= PH_IDLE;
    end else if (p1) begin
      state <= state_nxt;
    end
  end

  assign phase     = state;
  assign phase_nxt = state_nxt;

endmodule

// File: rtl/mcs4_rom_bus.sv
// rtl/mcs4_rom_bus.sv - 4001-style ROM/IO chip bus interface: fetch, SRC/WRR/RDR port
module mcs4_rom_bus
  import mcs4_pkg::*;
#(
  parameter logic [3:0] CHIP_ID = 4'h0,
  parameter logic [3:0] IO_MASK = 4'hF
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       clk1,
  input  logic       clk2,
  input  logic       sync,
  input  logic       cm_rom,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic       data_oe,
  output logic [7:0] rom_addr,
  output logic       rom_rd,
  input  logic [7:0] rom_data,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  output logic [2:0] phase
);

  logic [3:0] phase_cur;
  logic [3:0] phase_nxt;
  logic       p1;
  logic       p2f;
  logic       sel;
  logic       src_sel;
  logic [3:0] io_op;
  logic [3:0] rom_lo;
  logic       chip_match;
  logic       rdr_go;

  mcs4_phase_tracker u_tracker (
    .sysclk    (sysclk),
    .reset_n   (reset_n),
    .clk1      (clk1),
    .clk2      (clk2),
    .sync      (sync),
    .phase     (phase_cur),
    .phase_nxt (phase_nxt),
    .p1        (p1),
    .p2f       (p2f)
  );

  assign chip_match = (data_in == CHIP_ID);
  // A concurrent cm_rom in X2 means SRC, which overrides a pending RDR drive
  assign rdr_go     = (io_op == IO_RDR) && !cm_rom;
  assign phase      = (phase_cur == PH_IDLE) ? 3'd7 : phase_cur[2:0];

  // Drive windows open on the p1 entering a phase; bus sampling happens on p2f
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sel      <= 1'b0;
      src_sel  <= 1'b0;
      io_op    <= 4'h0;
      io_out   <= 4'h0;
      rom_addr <= 8'h00;
      rom_lo   <= 4'h0;
      rom_rd   <= 1'b0;
      data_oe  <= 1'b0;
      data_out <= 4'h0;
    end else begin
      rom_rd <= 1'b0;
      if (p1) begin
        data_oe  <= 1'b0;
        data_out <= 4'h0;
        case (phase_nxt)
          PH_A1: begin
            sel   <= 1'b0;
            io_op <= 4'h0;
          end
          PH_M1: begin
            rom_lo <= rom_data[3:0];
            if (sel) begin
              data_oe  <= 1'b1;
              data_out <= rom_data[7:4];
            end
          end
          PH_M2: begin
            if (sel) begin
              data_oe  <= 1'b1;
              data_out <= rom_lo;
            end
          end
          PH_X2: begin
            if (rdr_go) begin
              data_oe  <= 1'b1;
              data_out <= io_in & ~IO_MASK;
            end
          end
          default: ;
        endcase
      end
      if (p2f) begin
        case (phase_cur)
          PH_A1: rom_addr[3:0] <= data_in;
          PH_A2: rom_addr[7:4] <= data_in;
          PH_A3: begin
            sel    <= cm_rom & chip_match;
            rom_rd <= cm_rom & chip_match;
          end
          PH_M2: io_op <= (cm_rom && src_sel) ? data_in : 4'h0;
          PH_X2: begin
            if (cm_rom) begin
              src_sel  <= chip_match;
              data_oe  <= 1'b0;
              data_out <= 4'h0;
            end else if (io_op == IO_WRR) begin
              io_out <= data_in & IO_MASK;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcs4_rom_bus.sv
// tb/tb_mcs4_rom_bus.sv - scoreboard bench for mcs4_rom_bus with random instruction cycles
module tb_mcs4_rom_bus;

  localparam logic [3:0] CHIP = 4'h3;
  localparam logic [3:0] MASK = 4'hC;
  localparam logic [1:0] K_RD  = 2'd1;
  localparam logic [1:0] K_DRV = 2'd2;

  logic       sysclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clk1 = 1'b0;
  logic       clk2 = 1'b0;
  logic       sync = 1'b0;
  logic       cm_rom = 1'b0;
  logic [3:0] data_in = 4'h0;
  logic [3:0] data_out;
  logic       data_oe;
  logic [7:0] rom_addr;
  logic       rom_rd;
  logic [7:0] rom_data;
  logic [3:0] io_in = 4'h0;
  logic [3:0] io_out;
  logic [2:0] phase;

  logic [7:0] rom [0:255];
  assign rom_data = rom[rom_addr];

  typedef struct {
    logic [1:0] kind;
    logic [2:0] ph;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic       src_sel_m = 1'b0;
  logic [3:0] io_out_m = 4'h0;

  mcs4_rom_bus #(.CHIP_ID(CHIP), .IO_MASK(MASK)) dut (
    .sysclk   (sysclk),
    .reset_n  (reset_n),
    .clk1     (clk1),
    .clk2     (clk2),
    .sync     (sync),
    .cm_rom   (cm_rom),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .rom_addr (rom_addr),
    .rom_rd   (rom_rd),
    .rom_data (rom_data),
    .io_in    (io_in),
    .io_out   (io_out),
    .phase    (phase)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void push(input logic [1:0] k, input logic [2:0] ph, input logic [7:0] v);
    exp_t e;
    e.kind = k;
    e.ph   = ph;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  task automatic take(input logic [1:0] k, input logic [2:0] ph, input logic [7:0] v, input string nm);
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got unexpected event phase %0d value %h, required none at %0t", nm, ph, v, $time);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_kind"}, {6'd0, k}, {6'd0, e.kind});
      if (k == K_DRV) chk({nm, "_phase"}, {5'd0, ph}, {5'd0, e.ph});
      chk({nm, "_value"}, v, e.val);
    end
  endtask

  // Monitor: every rom_rd strobe and every new drive segment consumes one expectation
  logic       oe_q = 1'b0;
  logic [2:0] ph_q = 3'd7;
  always @(negedge sysclk) begin
    if (rom_rd) take(K_RD, 3'd0, rom_addr, "rom_rd_addr");
    if (data_oe && (!oe_q || phase != ph_q)) take(K_DRV, phase, {4'h0, data_out}, "drive");
    oe_q = data_oe;
    ph_q = phase;
  end

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_data_oe"}, {7'd0, data_oe}, 8'h00);
    chk({nm, "_data_out"}, {4'h0, data_out}, 8'h00);
    chk({nm, "_rom_addr"}, rom_addr, 8'h00);
    chk({nm, "_rom_rd"}, {7'd0, rom_rd}, 8'h00);
    chk({nm, "_io_out"}, {4'h0, io_out}, 8'h00);
    chk({nm, "_phase"}, {5'd0, phase}, 8'h07);
  endtask

  // One bus phase of 8 sysclk: clk1 high for 2, clk2 high for 2, bus values held all phase
  task automatic run_phase(input logic s, input logic c, input logic [3:0] d, input int rst_at);
    for (int t = 0; t < 8; t++) begin
      @(negedge sysclk);
      clk1 = (t < 2);
      clk2 = (t == 4 || t == 5);
      if (t == 0) begin
        sync    = s;
        cm_rom  = c;
        data_in = d;
      end
      if (t == rst_at) begin
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("mid_reset");
      end
    end
    if (rst_at >= 0) begin
      @(negedge sysclk);
      reset_n = 1'b1;
    end
  endtask

  task automatic idle_check(input string nm);
    run_phase(1'b0, 1'b0, 4'h0, -1);
    run_phase(1'b0, 1'b0, 4'h0, -1);
    chk({nm, "_phase"}, {5'd0, phase}, 8'h07);
    run_phase(1'b1, 1'b0, 4'h0, -1);
  endtask

  // Full instruction cycle; the model decides the bus events from the cycle's fields alone
  task automatic do_cycle(input logic [7:0] addr, input logic [3:0] chip, input logic cm3,
                          input logic cm_m2, input logic [3:0] m2d, input logic cm_x2,
                          input logic [3:0] x2d, input logic sync_end, input logic sync_m1,
                          input logic rst_m2);
    logic       selected;
    logic [3:0] op;
    logic [7:0] b;
    b = rom[addr];
    selected = cm3 && (chip == CHIP);
    if (selected) begin
      push(K_RD, 3'd0, addr);
      push(K_DRV, 3'd3, {4'h0, b[7:4]});
      if (!sync_m1) push(K_DRV, 3'd4, {4'h0, b[3:0]});
    end
    op = (cm_m2 && src_sel_m) ? m2d : 4'h0;
    if (!sync_m1 && !rst_m2) begin
      if (op == 4'hA && !cm_x2) push(K_DRV, 3'd6, {4'h0, io_in & ~MASK});
      if (cm_x2) src_sel_m = (x2d == CHIP);
      else if (op == 4'h2) io_out_m = x2d & MASK;
    end
    if (rst_m2) begin
      src_sel_m = 1'b0;
      io_out_m  = 4'h0;
    end
    run_phase(1'b0, 1'b0, addr[3:0], -1);
    run_phase(1'b0, 1'b0, addr[7:4], -1);
    run_phase(1'b0, cm3, chip, -1);
    run_phase(sync_m1, 1'b0, 4'h0, -1);
    if (sync_m1) return;
    run_phase(1'b0, cm_m2, m2d, rst_m2 ? 4 : -1);
    if (rst_m2) return;
    run_phase(1'b0, 1'b0, 4'h0, -1);
    run_phase(1'b0, cm_x2, x2d, -1);
    run_phase(sync_end, 1'b0, 4'h0, -1);
    chk("io_out", {4'h0, io_out}, {4'h0, io_out_m});
  endtask

  initial begin
    logic [3:0] ch;
    logic [3:0] m2;
    logic [3:0] x2;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'hA5] = 8'hD7;
    repeat (3) @(negedge sysclk);
    chk_reset_vals("reset");
    reset_n = 1'b1;
    run_phase(1'b1, 1'b0, 4'h0, -1);

    do_cycle(8'hA5, 4'h3, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    do_cycle(8'hA5, 4'h2, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    do_cycle(8'h10, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
    do_cycle(8'h11, 4'h0, 1'b0, 1'b1, 4'h2, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0);
    io_in = 4'hF;
    do_cycle(8'h12, 4'h0, 1'b0, 1'b1, 4'hA, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    do_cycle(8'h13, 4'h0, 1'b0, 1'b1, 4'hA, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      io_in = 4'($urandom);
      ch = ($urandom_range(0, 1) != 0) ? CHIP : 4'($urandom);
      case ($urandom_range(0, 2))
        0: m2 = 4'h2;
        1: m2 = 4'hA;
        default: m2 = 4'($urandom);
      endcase
      x2 = ($urandom_range(0, 1) != 0) ? CHIP : 4'($urandom);
      do_cycle(8'($urandom), ch, ($urandom_range(0, 3) != 0), 1'($urandom), m2,
               ($urandom_range(0, 2) == 0), x2, 1'b1, 1'b0, 1'b0);
    end

    do_cycle(8'h20, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    idle_check("sync_loss");
    do_cycle(8'hA5, CHIP, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    do_cycle(8'h33, CHIP, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    do_cycle(8'h44, 4'h0, 1'b0, 1'b1, 4'h2, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0);
    do_cycle(8'hA5, CHIP, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    chk("post_reset_io_out", {4'h0, io_out}, {4'h0, io_out_m});
    idle_check("post_reset");
    do_cycle(8'h5A, CHIP, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

    repeat (4) @(negedge sysclk);
    chk("queue_drain", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
